pix_pack: RTL and testbench

//  Upstream feeder of the per-line dark/bright vote buffer. Converts the RGB24

---
 rtl/dd_pkg.sv | 22 ++
 rtl/luma_calc.sv | 20 ++
 rtl/pix_pack.sv | 95 +++++++++
 tb/tb_pix_pack.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dd_pkg.sv
// rtl/dd_pkg.sv - shared video-path types and luma weights
package dd_pkg;
  localparam int LUMA_WR = 2;
  localparam int LUMA_WG = 5;
  localparam int LUMA_WB = 1;
  localparam int LUMA_SH = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Max weighted sum is 8*255 = 2040, so 11 bits never overflow.
  function automatic logic [7:0] luma_of(rgb_t p);
    logic [10:0] sum;
    sum = 11'(LUMA_WR) * {3'b000, p.r}
        + 11'(LUMA_WG) * {3'b000, p.g}
        + 11'(LUMA_WB) * {3'b000, p.b};
    return 8'(sum >> LUMA_SH);
  endfunction
endpackage

// File: rtl/luma_calc.sv
// rtl/luma_calc.sv - registered RGB to 8-bit luma stage
module luma_calc
  import dd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  rgb_t       rgb_i,
  output logic [7:0] luma_o
);
  logic [7:0] luma_d, luma_q;

  assign luma_d = luma_of(rgb_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) luma_q <= 8'd0;
    else       luma_q <= luma_d;
  end

  assign luma_o = luma_q;
endmodule

// File: rtl/pix_pack.sv
// rtl/pix_pack.sv - bright-pixel counter per group of an active run
// S1 luma, S2 threshold compare, S3 group accumulator; hs delayed to match.
module pix_pack
  import dd_pkg::*;
#(
  parameter int unsigned GROUP = 8,
  parameter int unsigned THRES = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hs_i,
  input  logic        de_i,
  input  logic [23:0] rgb_i,
  output logic        hs_o,
  output logic        de_o,
  output logic [7:0]  wd_o
);
  localparam int CNT_W = $clog2(GROUP + 1);

  rgb_t       rgb;
  logic [7:0] luma_s1;
  logic       de_s1_q, hs_s1_q;
  logic       bright_s2_q, de_s2_q, hs_s2_q;
  logic       hs_q, de_q, de_d;
  logic [7:0] wd_q, wd_d, acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       close;

  assign rgb = rgb_i;

  luma_calc u_luma (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .rgb_i  (rgb),
    .luma_o (luma_s1)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      de_s1_q     <= 1'b0;
      hs_s1_q     <= 1'b0;
      bright_s2_q <= 1'b0;
      de_s2_q     <= 1'b0;
      hs_s2_q     <= 1'b0;
      hs_q        <= 1'b0;
    end else begin
      de_s1_q     <= de_i;
      hs_s1_q     <= hs_i;
      bright_s2_q <= (luma_s1 >= 8'(THRES)) & de_s1_q;
      de_s2_q     <= de_s1_q;
      hs_s2_q     <= hs_s1_q;
      hs_q        <= hs_s2_q;
    end
  end

  // de_s1 is the de of the pixel following the one in S2, so its low
  // level marks the last pixel of the run and forces a flush.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    de_d    = 1'b0;
    acc_sum = acc_q + {7'd0, bright_s2_q};
    close   = de_s2_q & ((cnt_q == CNT_W'(GROUP - 1)) | ~de_s1_q);
    if (de_s2_q) begin
      if (close) begin
        wd_d  = acc_sum;
        de_d  = 1'b1;
        acc_d = 8'd0;
        cnt_d = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= 8'd0;
      cnt_q <= '0;
      wd_q  <= 8'd0;
      de_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      wd_q  <= wd_d;
      de_q  <= de_d;
    end
  end

  assign hs_o = hs_q;
  assign de_o = de_q;
  assign wd_o = wd_q;
endmodule

// File: tb/tb_pix_pack.sv
// tb/tb_pix_pack.sv - directed self-checking bench for pix_pack
module tb_pix_pack;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs_i = 1'b0;
  logic        de_i = 1'b0;
  logic [23:0] rgb_i = 24'd0;
  logic        hs_o, de_o;
  logic [7:0]  wd_o;

  typedef struct { int cyc; logic [7:0] wd; } strobe_t;
  strobe_t sq[$];
  int      cyc = 0;
  int      n_checks = 0;
  int      n_fail = 0;
  logic    hs_in_hist [0:4095];
  logic    hs_out_hist[0:4095];
  int      first_pix, last_pix;
  int      rel0, rst_at, rel1;
  int      exp_cyc[4];
  logic [7:0] exp_wd[4];
  int      n_exp;

  pix_pack #(.GROUP(8), .THRES(128)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hs_i  (hs_i),
    .de_i  (de_i),
    .rgb_i (rgb_i),
    .hs_o  (hs_o),
    .de_o  (de_o),
    .wd_o  (wd_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (cyc < 4096) begin
      hs_in_hist[cyc]  = hs_i;
      hs_out_hist[cyc] = hs_o;
    end
    if (de_o) sq.push_back('{cyc, wd_o});
  end

  task automatic step(input logic de, input logic [23:0] rgb);
    @(posedge clk);
    #1;
    de_i  = de;
    rgb_i = rgb;
    hs_i  = ((cyc % 9) < 3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 24'd0);
  endtask

  // mode: 0 white, 1 alternating white/black from white, 2 gray 7F, 3 gray 80
  task automatic run(input int n, input int mode);
    logic [23:0] px;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       px = 24'hFFFFFF;
        1:       px = (i % 2 == 0) ? 24'hFFFFFF : 24'h000000;
        2:       px = 24'h7F7F7F;
        default: px = 24'h808080;
      endcase
      step(1'b1, px);
      if (i == 0) first_pix = cyc;
      last_pix = cyc;
    end
  endtask

  task automatic check_strobes(input string name);
    n_checks++;
    if (sq.size() !== n_exp) begin
      n_fail++;
      $display("FAIL %s strobe_count got %0d exp %0d", name, sq.size(), n_exp);
    end
    for (int i = 0; i < n_exp && i < sq.size(); i++) begin
      n_checks++;
      if (sq[i].cyc !== exp_cyc[i] || sq[i].wd !== exp_wd[i]) begin
        n_fail++;
        $display("FAIL %s strobe%0d got cyc %0d wd %0d exp cyc %0d wd %0d",
                 name, i, sq[i].cyc, sq[i].wd, exp_cyc[i], exp_wd[i]);
      end
    end
    sq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      hs_i  = 1'($urandom);
      de_i  = 1'($urandom);
      rgb_i = 24'($urandom);
      @(negedge clk);
      n_checks++;
      if (hs_o !== 1'b0 || de_o !== 1'b0 || wd_o !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_outputs got hs %b de %b wd %0d exp 0 0 0", hs_o, de_o, wd_o);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0; de_i = 1'b0; rgb_i = 24'd0; hs_i = 1'b0;
    rel0 = cyc;
    sq.delete();
    idle(6);
    n_exp = 0;
    check_strobes("reset_idle");
  endtask

  task automatic test_full_groups();
    run(16, 0);
    idle(6);
    n_exp = 2;
    exp_cyc[0] = first_pix + 10; exp_wd[0] = 8'd8;
    exp_cyc[1] = first_pix + 18; exp_wd[1] = 8'd8;
    check_strobes("full_groups");
  endtask

  task automatic test_partial_flush();
    run(11, 1);
    idle(6);
    n_exp = 2;
    exp_cyc[0] = first_pix + 10; exp_wd[0] = 8'd4;
    exp_cyc[1] = last_pix + 3;   exp_wd[1] = 8'd2;
    check_strobes("partial_flush");
  endtask

  task automatic test_threshold();
    run(8, 2);
    exp_cyc[0] = last_pix + 3; exp_wd[0] = 8'd0;
    idle(2);
    run(8, 3);
    exp_cyc[1] = last_pix + 3; exp_wd[1] = 8'd8;
    idle(6);
    n_exp = 2;
    check_strobes("threshold");
  endtask

  task automatic test_back_to_back();
    run(8, 0);
    exp_cyc[0] = last_pix + 3; exp_wd[0] = 8'd8;
    idle(1);
    run(8, 0);
    exp_cyc[1] = last_pix + 3; exp_wd[1] = 8'd8;
    idle(1);
    run(1, 0);
    exp_cyc[2] = last_pix + 3; exp_wd[2] = 8'd1;
    idle(1);
    run(1, 2);
    exp_cyc[3] = last_pix + 3; exp_wd[3] = 8'd0;
    idle(6);
    n_exp = 4;
    check_strobes("back_to_back");
  endtask

  task automatic test_mid_reset();
    run(5, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rst_at = cyc;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; de_i = 1'b0; rgb_i = 24'd0; hs_i = ((cyc % 9) < 3);
    rel1 = cyc;
    idle(5);
    n_exp = 0;
    check_strobes("mid_reset_discard");
    run(8, 0);
    idle(6);
    n_exp = 1;
    exp_cyc[0] = last_pix + 3; exp_wd[0] = 8'd8;
    check_strobes("after_reset_run");
  endtask

  task automatic test_hs(input int lo, input int hi, input string name);
    for (int c = lo; c <= hi; c++) begin
      n_checks++;
      if (hs_out_hist[c + 3] !== hs_in_hist[c]) begin
        n_fail++;
        $display("FAIL %s cyc %0d got hs_o %b exp %b", name, c + 3, hs_out_hist[c + 3], hs_in_hist[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_groups();
    test_partial_flush();
    test_threshold();
    test_back_to_back();
    test_mid_reset();
    @(negedge clk);
    test_hs(rel0, rst_at - 4, "hs_delay_pre");
    test_hs(rel1, cyc - 4, "hs_delay_post");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
